vga_color_adapter: RTL and testbench
====================================

Name: vga_color_adapter

Overview:
- Parametrised colour/sync output stage between the `top` VGA outputs and the board resistor-DAC pins.
- Reduces wide per-channel colour (default 8 bits) to any board DAC width (444, 565, 666) by truncation, rounding, spatial ordered dither or spatio-temporal ordered dither.
- Delays hsync/vsync to stay aligned with the colour pipeline.
- Tracks pixel x/y and frame count itself from the sync and display_on strobes.

Parameters:
- W_IN, 8, input width of each colour channel.
- W_OUT_R, 6, red output width (1..W_IN+4).
- W_OUT_G, 6, green output width.
- W_OUT_B, 6, blue output width.
- MODE, 2, 0 = truncate, 1 = round-half-up, 2 = 4x4 ordered dither, 3 = ordered dither with frame rotation.
- SYNC_ACTIVE_LOW, 1, polarity of hsync/vsync on both the inputs and the outputs.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- pix_en  in  1  pixel strobe; the pipeline and counters advance only when this is 1.
- display_on  in  1  active-video qualifier.
- hsync_in  in  1  horizontal sync.
- vsync_in  in  1  vertical sync.
- red_in  in  W_IN  red input.
- green_in  in  W_IN  green input.
- blue_in  in  W_IN  blue input.
- hsync  out  1  delayed horizontal sync.
- vsync  out  1  delayed vertical sync.
- red  out  W_OUT_R  red output.
- green  out  W_OUT_G  green output.
- blue  out  W_OUT_B  blue output.

Behaviour:
- Single clock; rst is synchronous, active-high.
- While rst is high:
  - red, green and blue are 0.
  - hsync and vsync sit at their inactive level (1 if SYNC_ACTIVE_LOW, else 0).
  - x, y and frame counters are 0, and the pipeline valid/blank bits are cleared.
  - Reset mid-line takes effect on the next clock edge; outputs stay inactive until real data propagates.
- Pipeline:
  - Two stages, each advancing only on a clk edge with pix_en=1. pix_en=0 holds all state.
  - Latency is exactly 2 pix_en strobes for colour, hsync, vsync and display_on alike.
  - Stage 1 registers the inputs and the threshold selected from the counters.
  - Stage 2 adds, saturates, slices and registers the outputs.
- Counters (updated on pix_en=1 only, using the un-delayed inputs):
  - Sync "active edge" means the transition to the active level.
  - x (12-bit): increments when display_on=1; cleared on an hsync active edge.
  - y (12-bit): increments on an hsync active edge; cleared on a vsync active edge.
  - frame (2-bit): increments on a vsync active edge and wraps 3→0.
  - When hsync and vsync edges coincide, y clears; the vsync rule wins.
  - x and y wrap naturally at 4096.
- Threshold t (4-bit):
  - Bayer matrix B, row-major by y[1:0]: {0,8,2,10 / 12,4,14,6 / 3,11,1,9 / 15,7,13,5}, indexed by column c and row y[1:0].
  - MODE 2: c = x[1:0].
  - MODE 3: c = (x[1:0] + frame) mod 4.
- Per channel, with D = W_IN − W_OUT:
  - D = 0: pass-through in every mode.
  - D < 0: MSB-replicate the input to widen it; mode is ignored.
  - D > 0, MODE 0: output = in[W_IN−1:D].
  - D > 0, MODE 1: add 1<<(D−1), then slice.
  - D > 0, MODE 2/3: add a scaled threshold, then slice. The scaled threshold is t<<(D−4) if D ≥ 4, else t>>(4−D).
  - Every sum is W_IN+1 bits. On carry-out the output saturates to all-ones; it never wraps to 0.
- Blanking: if delayed display_on=0, all colour outputs are 0 regardless of mode. Sync outputs are never blanked.

Decomposition:
- Package vga_color_adapter_pkg holds:
  - the mode localparams (MODE_TRUNC, MODE_ROUND, MODE_DITHER, MODE_DITHER_T);
  - the 16-entry Bayer constant;
  - the function scale_threshold(t, D).
- One sub-module, color_quantizer, parameters W_IN, W_OUT, MODE:
  - inputs: value and threshold;
  - implements the stage-2 add/saturate/slice/replicate for one channel;
  - instantiated three times.

Test Plan:
- Reset: hold rst for 3 cycles with arbitrary inputs → red/green/blue = 0 and hsync = vsync = 1 (active-low), counters 0. Release rst → first valid pixel appears 2 pix_en strobes later.
- MODE 0, 8→6: in 8'hFF → 6'h3F; in 8'h83 → 6'h20. pix_en high every other clock → latency is still 2 strobes (4 clocks).
- MODE 1: in 8'h82 → 6'h21; in 8'hFE → 6'h3F (saturation, no wrap); in 8'h01 → 6'h00.
- MODE 2, flat 8'h81 over a 4x4 block from a vsync-reset origin:
  - exactly 4 of 16 pixels give 6'h21, at (x,y) = (0,1), (2,1), (0,3), (2,3); all others give 6'h20;
  - the pattern is unchanged on the next frame.
- MODE 3, same stimulus: after one vsync active edge the 6'h21 pixels move to x = 3 and x = 1 on rows 1 and 3; after four frames the pattern returns to the original.
- Blanking/sync: display_on=0 during the porch with input 8'hFF → colour 0. An hsync pulse asserted at strobe n appears on the hsync output at strobe n+2 with identical width. A 4:4:4 config (W_OUT=4) and a widening config (W_IN=4, W_OUT=6: 4'hA → 6'h2A) both check correctly.

Source files
------------

// File: rtl/vga_color_adapter_pkg.sv
// Shared constants and helpers for the VGA colour/sync output stage.
package vga_color_adapter_pkg;

  localparam int MODE_TRUNC    = 0;
  localparam int MODE_ROUND    = 1;
  localparam int MODE_DITHER   = 2;
  localparam int MODE_DITHER_T = 3;

  // 4x4 Bayer matrix, row-major: index = {row[1:0], col[1:0]}
  localparam logic [3:0] BAYER [16] = '{
    4'd0,  4'd8,  4'd2,  4'd10,
    4'd12, 4'd4,  4'd14, 4'd6,
    4'd3,  4'd11, 4'd1,  4'd9,
    4'd15, 4'd7,  4'd13, 4'd5
  };

  function automatic logic [31:0] scale_threshold(input logic [3:0] t, input int d);
    logic [31:0] t_ext;
    t_ext = {28'd0, t};
    if (d >= 4) begin
      scale_threshold = t_ext << (d - 4);
    end else begin
      scale_threshold = t_ext >> (4 - d);
    end
  endfunction

endpackage

// File: rtl/vga_color_adapter_quantizer.sv
// Per-channel width adapter: pass-through, MSB replication, or
// add/saturate/slice for truncation, rounding and ordered dither.
module color_quantizer
  import vga_color_adapter_pkg::*;
#(
  parameter int W_IN  = 8,
  parameter int W_OUT = 6,
  parameter int MODE  = MODE_DITHER
) (
  input  logic [W_IN-1:0]  value_i,
  input  logic [3:0]       threshold_i,
  output logic [W_OUT-1:0] result_o
);

  localparam int D  = W_IN - W_OUT;
  localparam int WS = W_IN + 1;

  generate
    if (D == 0) begin : g_pass
      logic unused_thr_s;
      assign unused_thr_s = ^threshold_i;
      assign result_o     = value_i;
    end else if (D < 0) begin : g_widen
      localparam int REP = (W_OUT + W_IN - 1) / W_IN;
      logic [REP*W_IN-1:0] rep_s;
      logic                unused_thr_s;
      assign unused_thr_s = ^threshold_i;
      assign rep_s        = {REP{value_i}};
      assign result_o     = rep_s[REP*W_IN-1 -: W_OUT];
    end else begin : g_narrow
      logic [W_IN:0] addend_s;
      logic [W_IN:0] sum_s;
      logic          unused_low_s;

      // Pick the rounding/dither offset added below the kept bits.
      always_comb begin
        addend_s = {WS{1'b0}};
        case (MODE)
          MODE_TRUNC:                 addend_s = {WS{1'b0}};
          MODE_ROUND:                 addend_s = WS'(32'd1 << (D - 1));
          MODE_DITHER, MODE_DITHER_T: addend_s = WS'(scale_threshold(threshold_i, D));
          default:                    addend_s = {WS{1'b0}};
        endcase
      end

      assign sum_s        = {1'b0, value_i} + addend_s;
      assign unused_low_s = ^sum_s[D-1:0];
      // A carry-out means the value overflowed: clamp to full scale.
      assign result_o     = sum_s[W_IN] ? {W_OUT{1'b1}} : sum_s[W_IN-1:D];
    end
  endgenerate

endmodule

// File: rtl/vga_color_adapter.sv
// Two-stage colour/sync output stage: per-pixel threshold selection,
// channel quantisation, blanking and sync delay matched to the colour path.
module vga_color_adapter
  import vga_color_adapter_pkg::*;
#(
  parameter int W_IN            = 8,
  parameter int W_OUT_R         = 6,
  parameter int W_OUT_G         = 6,
  parameter int W_OUT_B         = 6,
  parameter int MODE            = MODE_DITHER,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  input  logic               display_on,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [W_IN-1:0]    red_in,
  input  logic [W_IN-1:0]    green_in,
  input  logic [W_IN-1:0]    blue_in,
  output logic               hsync,
  output logic               vsync,
  output logic [W_OUT_R-1:0] red,
  output logic [W_OUT_G-1:0] green,
  output logic [W_OUT_B-1:0] blue
);

  localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic SYNC_ACT  = ~SYNC_IDLE;

  logic [11:0] x_q, x_d, y_q, y_d;
  logic [1:0]  frame_q, frame_d;
  logic        hs_prev_q, vs_prev_q;
  logic        hs_act_s, vs_act_s, hs_edge_s, vs_edge_s;
  logic [1:0]  col_s;
  logic [3:0]  thr_s;

  logic [W_IN-1:0] red1_q, green1_q, blue1_q;
  logic [3:0]      thr1_q;
  logic            hs1_q, vs1_q, de1_q;

  logic [W_OUT_R-1:0] red_s, red_q;
  logic [W_OUT_G-1:0] green_s, green_q;
  logic [W_OUT_B-1:0] blue_s, blue_q;
  logic               hsync_q, vsync_q;

  assign hs_act_s  = (hsync_in == SYNC_ACT);
  assign vs_act_s  = (vsync_in == SYNC_ACT);
  assign hs_edge_s = hs_act_s & ~hs_prev_q;
  assign vs_edge_s = vs_act_s & ~vs_prev_q;

  // Raster position and frame tracking; a vsync edge overrides the hsync row step.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    frame_d = frame_q;
    if (hs_edge_s) begin
      x_d = 12'd0;
    end else if (display_on) begin
      x_d = x_q + 12'd1;
    end else begin
      x_d = x_q;
    end
    if (vs_edge_s) begin
      y_d     = 12'd0;
      frame_d = frame_q + 2'd1;
    end else if (hs_edge_s) begin
      y_d     = y_q + 12'd1;
      frame_d = frame_q;
    end else begin
      y_d     = y_q;
      frame_d = frame_q;
    end
  end

  // Bayer threshold for the pixel currently at the input; temporal mode shifts columns per frame.
  always_comb begin
    col_s = x_q[1:0];
    if (MODE == MODE_DITHER_T) begin
      col_s = x_q[1:0] + frame_q;
    end else begin
      col_s = x_q[1:0];
    end
    thr_s = BAYER[{y_q[1:0], col_s}];
  end

  color_quantizer #(.W_IN(W_IN), .W_OUT(W_OUT_R), .MODE(MODE)) u_quant_r (
    .value_i(red1_q), .threshold_i(thr1_q), .result_o(red_s)
  );
  color_quantizer #(.W_IN(W_IN), .W_OUT(W_OUT_G), .MODE(MODE)) u_quant_g (
    .value_i(green1_q), .threshold_i(thr1_q), .result_o(green_s)
  );
  color_quantizer #(.W_IN(W_IN), .W_OUT(W_OUT_B), .MODE(MODE)) u_quant_b (
    .value_i(blue1_q), .threshold_i(thr1_q), .result_o(blue_s)
  );

  // Counters plus both pipeline stages; everything holds while pix_en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= 12'd0;
      y_q       <= 12'd0;
      frame_q   <= 2'd0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      red1_q    <= {W_IN{1'b0}};
      green1_q  <= {W_IN{1'b0}};
      blue1_q   <= {W_IN{1'b0}};
      thr1_q    <= 4'd0;
      hs1_q     <= SYNC_IDLE;
      vs1_q     <= SYNC_IDLE;
      de1_q     <= 1'b0;
      red_q     <= {W_OUT_R{1'b0}};
      green_q   <= {W_OUT_G{1'b0}};
      blue_q    <= {W_OUT_B{1'b0}};
      hsync_q   <= SYNC_IDLE;
      vsync_q   <= SYNC_IDLE;
    end else if (pix_en) begin
      x_q       <= x_d;
      y_q       <= y_d;
      frame_q   <= frame_d;
      hs_prev_q <= hs_act_s;
      vs_prev_q <= vs_act_s;
      red1_q    <= red_in;
      green1_q  <= green_in;
      blue1_q   <= blue_in;
      thr1_q    <= thr_s;
      hs1_q     <= hsync_in;
      vs1_q     <= vsync_in;
      de1_q     <= display_on;
      red_q     <= de1_q ? red_s   : {W_OUT_R{1'b0}};
      green_q   <= de1_q ? green_s : {W_OUT_G{1'b0}};
      blue_q    <= de1_q ? blue_s  : {W_OUT_B{1'b0}};
      hsync_q   <= hs1_q;
      vsync_q   <= vs1_q;
    end
  end

  assign red   = red_q;
  assign green = green_q;
  assign blue  = blue_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;

endmodule

// File: tb/tb_vga_color_adapter.sv
// Directed bench for vga_color_adapter across truncate, round, dither,
// temporal dither, 4:4:4 and widening configurations.
module tb_vga_color_adapter;

  logic       clk, rst, pix_en, display_on, hsync_in, vsync_in;
  logic [7:0] red_in, green_in, blue_in;
  logic [3:0] red4_in, green4_in, blue4_in;

  logic       t_hs, t_vs, r_hs, r_vs, d_hs, d_vs, dt_hs, dt_vs, f_hs, f_vs, w_hs, w_vs;
  logic [5:0] t_r, t_g, t_b, r_r, r_g, r_b, d_r, d_g, d_b, dt_r, dt_g, dt_b, w_r, w_g, w_b;
  logic [3:0] f_r, f_g, f_b;

  int n_checks;
  int n_errors;

  logic [7:0] vec   [6];
  logic [3:0] wvec  [6];
  logic [5:0] exp_t [6];
  logic [5:0] exp_r [6];
  logic [3:0] exp_f [6];
  logic [5:0] exp_w [6];
  logic       hs_pat [8];
  logic       vs_pat [8];

  vga_color_adapter #(.MODE(0)) u_trunc (
    .clk(clk), .rst(rst), .pix_en(pix_en), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .hsync(t_hs), .vsync(t_vs), .red(t_r), .green(t_g), .blue(t_b));

  vga_color_adapter #(.MODE(1)) u_round (
    .clk(clk), .rst(rst), .pix_en(pix_en), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .hsync(r_hs), .vsync(r_vs), .red(r_r), .green(r_g), .blue(r_b));

  vga_color_adapter #(.MODE(2)) u_dith (
    .clk(clk), .rst(rst), .pix_en(pix_en), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .hsync(d_hs), .vsync(d_vs), .red(d_r), .green(d_g), .blue(d_b));

  vga_color_adapter #(.MODE(3)) u_dith_t (
    .clk(clk), .rst(rst), .pix_en(pix_en), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .hsync(dt_hs), .vsync(dt_vs), .red(dt_r), .green(dt_g), .blue(dt_b));

  vga_color_adapter #(.W_OUT_R(4), .W_OUT_G(4), .W_OUT_B(4), .MODE(0)) u_444 (
    .clk(clk), .rst(rst), .pix_en(pix_en), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .hsync(f_hs), .vsync(f_vs), .red(f_r), .green(f_g), .blue(f_b));

  vga_color_adapter #(.W_IN(4), .MODE(2), .SYNC_ACTIVE_LOW(1'b0)) u_wide (
    .clk(clk), .rst(rst), .pix_en(pix_en), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .red_in(red4_in), .green_in(green4_in), .blue_in(blue4_in),
    .hsync(w_hs), .vsync(w_vs), .red(w_r), .green(w_g), .blue(w_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One pix_en strobe, then idle clocks with pix_en low; returns #1 after an edge.
  task automatic strobe(input int idle);
    pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0;
    repeat (idle) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drive(input logic de, input logic hs, input logic vs,
                       input logic [7:0] v, input logic [3:0] w);
    display_on = de;
    hsync_in   = hs;
    vsync_in   = vs;
    red_in     = v;
    green_in   = v;
    blue_in    = v;
    red4_in    = w;
    green4_in  = w;
    blue4_in   = w;
  endtask

  task automatic check_pix(input int r, input int c, input int f);
    logic [5:0] e2, e3;
    e2 = ((r % 2 == 1) && (c % 2 == 0)) ? 6'h21 : 6'h20;
    e3 = ((r % 2 == 1) && ((c + f) % 2 == 0)) ? 6'h21 : 6'h20;
    check_value($sformatf("dither r%0d c%0d f%0d", r, c, f), {26'd0, d_r}, {26'd0, e2});
    check_value($sformatf("dither_t r%0d c%0d f%0d", r, c, f), {26'd0, dt_r}, {26'd0, e3});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    vec   = '{8'hFF, 8'h83, 8'h82, 8'hFE, 8'h01, 8'hA5};
    exp_t = '{6'h3F, 6'h20, 6'h20, 6'h3F, 6'h00, 6'h29};
    exp_r = '{6'h3F, 6'h21, 6'h21, 6'h3F, 6'h00, 6'h29};
    exp_f = '{4'hF, 4'h8, 4'h8, 4'hF, 4'h0, 4'hA};
    wvec  = '{4'hA, 4'h0, 4'hF, 4'h5, 4'hA, 4'h0};
    exp_w = '{6'h2A, 6'h00, 6'h3F, 6'h15, 6'h2A, 6'h00};
    hs_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vs_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    // Reset with active-looking inputs and pix_en high
    rst    = 1'b1;
    pix_en = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 8'h5A, 4'h3);
    pix_en = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    pix_en = 1'b0;
    check_value("rst red",    {26'd0, t_r}, 32'h0);
    check_value("rst green",  {26'd0, t_g}, 32'h0);
    check_value("rst blue",   {26'd0, t_b}, 32'h0);
    check_value("rst hsync",  {31'd0, t_hs}, 32'h1);
    check_value("rst vsync",  {31'd0, t_vs}, 32'h1);
    check_value("rst hsync active-high", {31'd0, w_hs}, 32'h0);
    check_value("rst x",      {20'd0, u_dith_t.x_q}, 32'h0);
    check_value("rst y",      {20'd0, u_dith_t.y_q}, 32'h0);
    check_value("rst frame",  {30'd0, u_dith_t.frame_q}, 32'h0);

    drive(1'b0, 1'b1, 1'b1, 8'h00, 4'h0);
    rst = 1'b0;

    // Colour stream with pix_en every other clock: output lags exactly two strobes
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b1, vec[i], wvec[i]);
      strobe(1);
      if (i == 0) begin
        check_value("latency first strobe", {26'd0, t_r}, 32'h0);
      end else begin
        check_value($sformatf("trunc red %0d", i - 1),   {26'd0, t_r}, {26'd0, exp_t[i-1]});
        check_value($sformatf("trunc green %0d", i - 1), {26'd0, t_g}, {26'd0, exp_t[i-1]});
        check_value($sformatf("trunc blue %0d", i - 1),  {26'd0, t_b}, {26'd0, exp_t[i-1]});
        check_value($sformatf("round red %0d", i - 1),   {26'd0, r_r}, {26'd0, exp_r[i-1]});
        check_value($sformatf("444 red %0d", i - 1),     {28'd0, f_r}, {28'd0, exp_f[i-1]});
        check_value($sformatf("widen red %0d", i - 1),   {26'd0, w_r}, {26'd0, exp_w[i-1]});
      end
    end
    drive(1'b0, 1'b1, 1'b1, 8'hFF, 4'hF);
    strobe(1);
    check_value("trunc red 5", {26'd0, t_r}, {26'd0, exp_t[5]});
    check_value("round red 5", {26'd0, r_r}, {26'd0, exp_r[5]});
    check_value("444 red 5",   {28'd0, f_r}, {28'd0, exp_f[5]});
    check_value("widen red 5", {26'd0, w_r}, {26'd0, exp_w[5]});
    strobe(1);
    check_value("blank trunc", {26'd0, t_r}, 32'h0);
    check_value("blank round", {26'd0, r_r}, 32'h0);
    check_value("blank 444",   {28'd0, f_r}, 32'h0);
    check_value("blank widen", {26'd0, w_r}, 32'h0);

    // Sync pulses in porch: delayed by two strobes, width preserved, colour blanked
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, hs_pat[k], vs_pat[k], 8'hFF, 4'hF);
      strobe(0);
      if (k >= 1) begin
        check_value($sformatf("hsync step %0d", k), {31'd0, t_hs}, {31'd0, hs_pat[k-1]});
        check_value($sformatf("vsync step %0d", k), {31'd0, t_vs}, {31'd0, vs_pat[k-1]});
        check_value($sformatf("hsync widen step %0d", k), {31'd0, w_hs}, {31'd0, hs_pat[k-1]});
        check_value($sformatf("porch colour %0d", k), {26'd0, t_r}, 32'h0);
      end
    end

    // Reset in the middle of active video
    drive(1'b1, 1'b1, 1'b1, 8'hFF, 4'hF);
    strobe(0);
    strobe(0);
    check_value("pre-reset red", {26'd0, t_r}, 32'h3F);
    rst = 1'b1;
    @(posedge clk); #1;
    check_value("mid rst red",   {26'd0, t_r}, 32'h0);
    check_value("mid rst hsync", {31'd0, t_hs}, 32'h1);
    check_value("mid rst x",     {20'd0, u_dith_t.x_q}, 32'h0);
    check_value("mid rst frame", {30'd0, u_dith_t.frame_q}, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 8'h81, 4'h0);
    rst = 1'b0;

    // Flat 8'h81 over 4x4 blocks: frame 0 from reset, then four vsync-started frames
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        drive(1'b0, 1'b0, 1'b0, 8'h81, 4'h0);
        strobe(0);
      end
      drive(1'b0, 1'b1, 1'b1, 8'h81, 4'h0);
      strobe(0);
      for (int r = 0; r < 4; r++) begin
        if (r > 0) begin
          drive(1'b0, 1'b0, 1'b1, 8'h81, 4'h0);
          strobe(0);
          drive(1'b0, 1'b1, 1'b1, 8'h81, 4'h0);
          strobe(0);
        end
        for (int c = 0; c < 4; c++) begin
          drive(1'b1, 1'b1, 1'b1, 8'h81, 4'h0);
          strobe(0);
          if (c > 0) begin
            check_pix(r, c - 1, k % 4);
          end
        end
        drive(1'b0, 1'b1, 1'b1, 8'h81, 4'h0);
        strobe(0);
        check_pix(r, 3, k % 4);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
